// File: rtl/am_search_pkg.sv
// Shared constants and FSM state type for the associative-memory search block.
package hdc_pkg;
  localparam int HV_DIM       = 5000;
  localparam int DIMS_PER_CC  = 500;
  localparam int NUM_CLASSES  = 26;
  localparam int NUM_SEGMENTS = 10;
  localparam int SCORE_W      = 13;
  localparam int POP_W        = 9;
  localparam int CTR_W        = 4;
  localparam int CLASS_W      = $clog2(NUM_CLASSES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/am_search_if.sv
// Segment-feed and result bus for am_search; AM_SCORES_OUT_EN adds the per-class score vector.
interface am_search_if;
  import hdc_pkg::*;

  logic                                     start;
  logic [DIMS_PER_CC-1:0]                   query_hv_segment;
  logic [NUM_CLASSES-1:0][DIMS_PER_CC-1:0]  class_hv_segments;
  logic [CTR_W-1:0]                         query_ctr;
  logic                                     busy;
  logic                                     done;
  logic [CLASS_W-1:0]                       predicted_class;
  logic [SCORE_W-1:0]                       best_score;
`ifdef AM_SCORES_OUT_EN
  logic [NUM_CLASSES-1:0][SCORE_W-1:0]      class_scores;
`endif

  modport master (
    output start, query_hv_segment, class_hv_segments,
`ifdef AM_SCORES_OUT_EN
    input  class_scores,
`endif
    input  query_ctr, busy, done, predicted_class, best_score
  );

  modport slave (
    input  start, query_hv_segment, class_hv_segments,
`ifdef AM_SCORES_OUT_EN
    output class_scores,
`endif
    output query_ctr, busy, done, predicted_class, best_score
  );
endinterface

// File: rtl/am_search_popcount_seg.sv
// Combinational population count of one query/class overlap segment.
module popcount_seg #(
  parameter int W     = 500,
  parameter int CNT_W = 9
) (
  input  logic [W-1:0]     seg,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + CNT_W'(seg[i]);
  end
endmodule

// File: rtl/am_search.sv
// Hamming-overlap associative memory search: segment-serial popcount accumulation, then a serial argmax.
// Optional macro AM_SCORES_OUT_EN exports the final per-class accumulator values.
module am_search
  import hdc_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  am_search_if.slave bus
);
  localparam logic [CTR_W-1:0]   LAST_SEG   = CTR_W'(NUM_SEGMENTS - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  state_t               state, state_nxt;
  logic [CTR_W-1:0]     query_ctr;
  logic [POP_W-1:0]     pop_p0 [NUM_CLASSES];
  logic [POP_W-1:0]     pop_p1 [NUM_CLASSES];
  logic [SCORE_W-1:0]   acc_p2 [NUM_CLASSES];
  logic [CLASS_W-1:0]   scan_idx, run_idx, nxt_idx;
  logic [SCORE_W-1:0]   run_score, nxt_score, cand;
  logic [CLASS_W-1:0]   pred_q;
  logic [SCORE_W-1:0]   best_q;
  logic                 busy_c, done_c;
`ifdef AM_SCORES_OUT_EN
  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores_q;
`endif

  // p0: per-class overlap count of the current segment
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pop
    popcount_seg #(.W(DIMS_PER_CC), .CNT_W(POP_W)) u_pop (
      .seg   (bus.query_hv_segment & bus.class_hv_segments[k]),
      .count (pop_p0[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (query_ctr == LAST_SEG) state_nxt = DRAIN;
      DRAIN:   state_nxt = ARGMAX;
      ARGMAX:  if (scan_idx == LAST_CLASS) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    cand      = acc_p2[scan_idx];
    nxt_score = run_score;
    nxt_idx   = run_idx;
    if (cand > run_score) begin
      nxt_score = cand;
      nxt_idx   = scan_idx;
    end
  end

  // p1: registered popcounts; p2: accumulators, one segment behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_ctr <= '0;
      scan_idx  <= '0;
      run_idx   <= '0;
      run_score <= '0;
      pred_q    <= '0;
      best_q    <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        pop_p1[k] <= '0;
        acc_p2[k] <= '0;
      end
`ifdef AM_SCORES_OUT_EN
      scores_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          query_ctr <= '0;
          for (int k = 0; k < NUM_CLASSES; k++) begin
            pop_p1[k] <= '0;
            acc_p2[k] <= '0;
          end
        end
        ACCUM: begin
          if (query_ctr != LAST_SEG) query_ctr <= query_ctr + 1'b1;
          for (int k = 0; k < NUM_CLASSES; k++) begin
            pop_p1[k] <= pop_p0[k];
            acc_p2[k] <= acc_p2[k] + SCORE_W'(pop_p1[k]);
          end
        end
        DRAIN: begin
          for (int k = 0; k < NUM_CLASSES; k++)
            acc_p2[k] <= acc_p2[k] + SCORE_W'(pop_p1[k]);
          scan_idx  <= '0;
          run_idx   <= '0;
          run_score <= '0;
        end
        ARGMAX: begin
          run_score <= nxt_score;
          run_idx   <= nxt_idx;
          if (scan_idx != LAST_CLASS) begin
            scan_idx <= scan_idx + 1'b1;
          end else begin
            pred_q <= nxt_idx;
            best_q <= nxt_score;
`ifdef AM_SCORES_OUT_EN
            for (int k = 0; k < NUM_CLASSES; k++) scores_q[k] <= acc_p2[k];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.query_ctr       = query_ctr;
  assign bus.busy            = busy_c;
  assign bus.done            = done_c;
  assign bus.predicted_class = pred_q;
  assign bus.best_score      = best_q;
`ifdef AM_SCORES_OUT_EN
  assign bus.class_scores    = scores_q;
`endif
endmodule

// File: tb/tb_am_search.sv
// Directed and randomized bench for am_search against a whole-hypervector overlap/argmax model.
module tb_am_search;
  import hdc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  am_search_if bus();

  logic [HV_DIM-1:0] query_hv;
  logic [HV_DIM-1:0] class_hv [NUM_CLASSES];
  int exp_pred, exp_best;
  int exp_scores [NUM_CLASSES];
  int n_vec = 0;
  int n_err = 0;

  am_search dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Class memory and query mux, addressed by the DUT's segment counter
  always_comb begin
    bus.query_hv_segment = '0;
    for (int k = 0; k < NUM_CLASSES; k++) bus.class_hv_segments[k] = '0;
    if (int'(bus.query_ctr) < NUM_SEGMENTS) begin
      bus.query_hv_segment = query_hv[int'(bus.query_ctr)*DIMS_PER_CC +: DIMS_PER_CC];
      for (int k = 0; k < NUM_CLASSES; k++)
        bus.class_hv_segments[k] = class_hv[k][int'(bus.query_ctr)*DIMS_PER_CC +: DIMS_PER_CC];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full-vector overlap per class, first maximum wins
  task automatic model();
    exp_pred = 0;
    exp_best = -1;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      exp_scores[k] = $countones(query_hv & class_hv[k]);
      if (exp_scores[k] > exp_best) begin
        exp_best = exp_scores[k];
        exp_pred = k;
      end
    end
  endtask

  task automatic set_range(inout logic [HV_DIM-1:0] v, input int lo, input int n);
    for (int i = lo; i < lo + n; i++) v[i] = 1'b1;
  endtask

  task automatic clear_all();
    query_hv = '0;
    for (int k = 0; k < NUM_CLASSES; k++) class_hv[k] = '0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_pred"}, int'(bus.predicted_class), exp_pred);
    check({tag, "_best"}, int'(bus.best_score), exp_best);
`ifdef AM_SCORES_OUT_EN
    for (int k = 0; k < NUM_CLASSES; k++)
      check($sformatf("%s_score%0d", tag, k), int'(bus.class_scores[k]), exp_scores[k]);
`endif
  endtask

  task automatic run_search(input string tag);
    int lat;
    model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 12 + NUM_CLASSES);
    check_result(tag);
    @(negedge clk);
    check({tag, "_pulse"}, int'(bus.done), 0);
    check_result({tag, "_hold"});
  endtask

  initial begin
    int done_cyc [$];
    int idle_cyc [$];
    int seen_done;
    int dens_q, dens_c;
    logic [HV_DIM-1:0] tmp;

    bus.start = 1'b0;
    rst_n = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    check("rst_ctr",  int'(bus.query_ctr), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_pred", int'(bus.predicted_class), 0);
    check("rst_best", int'(bus.best_score), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single perfect match in class 3
    clear_all();
    query_hv = '1;
    class_hv[3] = '1;
    run_search("onehot3");
    check("onehot3_pred_c", int'(bus.predicted_class), 3);
    check("onehot3_best_c", int'(bus.best_score), 5000);

    // Empty query: all scores zero, class 0 wins
    clear_all();
    for (int k = 0; k < NUM_CLASSES; k++) class_hv[k] = '1;
    run_search("zeroq");
    check("zeroq_pred_c", int'(bus.predicted_class), 0);
    check("zeroq_best_c", int'(bus.best_score), 0);

    // Tie between classes 5 and 9 resolves to the lower index
    clear_all();
    set_range(query_hv, 0, 2000);
    for (int k = 0; k < NUM_CLASSES; k++) begin
      tmp = '0;
      set_range(tmp, 0, 100);
      set_range(tmp, 3000, 50);
      class_hv[k] = tmp;
    end
    tmp = '0;
    set_range(tmp, 700, 1200);
    set_range(tmp, 4000, 300);
    class_hv[5] = tmp;
    class_hv[9] = tmp;
    run_search("tie");
    check("tie_pred_c", int'(bus.predicted_class), 5);
    check("tie_best_c", int'(bus.best_score), 1200);

    // Graded overlap 100*k, class 25 wins with 2500
    clear_all();
    query_hv = '1;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      tmp = '0;
      set_range(tmp, 4999 - 100*k + 1, 100*k);
      class_hv[k] = tmp;
    end
    run_search("graded");
    check("graded_pred_c", int'(bus.predicted_class), 25);
    check("graded_best_c", int'(bus.best_score), 2500);

    // Randomized hypervectors
    for (int t = 0; t < 4; t++) begin
      dens_q = $urandom_range(80, 20);
      query_hv = '0;
      for (int i = 0; i < HV_DIM; i++) query_hv[i] = ($urandom_range(99) < dens_q);
      for (int k = 0; k < NUM_CLASSES; k++) begin
        dens_c = $urandom_range(90, 10);
        tmp = '0;
        for (int i = 0; i < HV_DIM; i++) tmp[i] = ($urandom_range(99) < dens_c);
        class_hv[k] = tmp;
      end
      run_search($sformatf("rand%0d", t));
    end

    // start held high: two back-to-back searches, one idle cycle between
    model();
    @(negedge clk); bus.start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.done) done_cyc.push_back(n);
      if (!bus.busy) idle_cyc.push_back(n);
      if (n == 39) check_result("b2b_first");
      if (n == 50) bus.start = 1'b0;
    end
    check("b2b_ndone", done_cyc.size(), 2);
    check("b2b_done1", (done_cyc.size() > 0) ? done_cyc[0] : -1, 38);
    check("b2b_done2", (done_cyc.size() > 1) ? done_cyc[1] : -1, 77);
    check("b2b_idle1", (idle_cyc.size() > 0) ? idle_cyc[0] : -1, 39);
    check("b2b_idle2", (idle_cyc.size() > 1) ? idle_cyc[1] : -1, 78);
    check_result("b2b_second");

    // Reset mid-accumulation while query_ctr == 4
    clear_all();
    query_hv = '1;
    class_hv[7] = '1;
    class_hv[2] = '1;
    for (int i = 0; i < HV_DIM; i += 2) class_hv[2][i] = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int n = 0; n < 20 && int'(bus.query_ctr) != 4; n++) @(negedge clk);
    check("rst_mid_ctr4", int'(bus.query_ctr), 4);
    rst_n = 1'b0;
    #1;
    check("rstm_ctr",  int'(bus.query_ctr), 0);
    check("rstm_busy", int'(bus.busy), 0);
    check("rstm_done", int'(bus.done), 0);
    check("rstm_pred", int'(bus.predicted_class), 0);
    check("rstm_best", int'(bus.best_score), 0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("rstm_nodone", seen_done, 0);
    run_search("after_rst");
    check("after_rst_pred_c", int'(bus.predicted_class), 7);
    check("after_rst_best_c", int'(bus.best_score), 5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
